// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
// Shared definitions for the iterative 16-bit multiply/divide unit:
// operation encodings, FSM state encoding, iteration count and a
// magnitude helper used when latching signed operands.
package muldiv_unit_pkg;

    // Operation select encodings (op input)
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_FIX  = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    // One shift-add / shift-subtract step per operand bit
    localparam int unsigned ITER_COUNT = 16;
    localparam logic [4:0]  ITER_LAST  = 5'(ITER_COUNT - 1);

    // Two's-complement magnitude; abs(0x8000) stays 0x8000 read as unsigned.
    function automatic logic [15:0] abs16(input logic [15:0] v);
        return v[15] ? (~v + 16'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative 16-bit multiply/divide unit. A start pulse in IDLE launches
// MULTU/MULT/DIVU/DIV; 16 CALC steps, one FIX (sign correction) cycle and a
// one-cycle DONE write pulse follow, for a fixed 18-cycle latency.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   start        in   launch request, sampled only in IDLE
//   op[1:0]      in   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a[15:0]      in   multiplicand / dividend, sampled with start
//   b[15:0]      in   multiplier / divisor, sampled with start
//   busy         out  high while state != IDLE
//   done         out  one-cycle completion pulse
//   div_by_zero  out  qualifies done for a divide with b == 0
//   hi_we        out  HI write enable (with done)
//   lo_we        out  LO write enable (with done)
//   hi_data      out  product[31:16] or remainder
//   lo_data      out  product[15:0] or quotient
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic        hi_we,
    output logic        lo_we,
    output logic [15:0] hi_data,
    output logic [15:0] lo_data
);

    logic [1:0]  state;
    logic [4:0]  iter_cnt;
    logic [1:0]  op_reg;
    logic [15:0] a_raw;       // original dividend, returned as HI on divide by zero
    logic [15:0] b_mag;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] acc;         // mult: {partial, multiplier}; div: {remainder, quotient}

    logic [15:0] a_in_mag;
    logic [15:0] b_in_mag;
    logic        a_in_neg;
    logic        b_in_neg;

    logic [16:0] mul_sum;
    logic [31:0] mul_next;
    logic [16:0] rem_shift;
    logic [16:0] div_diff;
    logic [31:0] div_next;

    logic [31:0] prod_fixed;
    logic [15:0] quot_fixed;
    logic [15:0] rem_fixed;
    logic [15:0] fix_hi;
    logic [15:0] fix_lo;
    logic        fix_dbz;

    assign busy = (state != ST_IDLE);

    // Operand capture: magnitudes only for signed ops (op[0] set)
    always_comb begin
        a_in_neg = op[0] & a[15];
        b_in_neg = op[0] & b[15];
        a_in_mag = a_in_neg ? abs16(a) : a;
        b_in_mag = b_in_neg ? abs16(b) : b;
    end

    // One multiply step: add multiplicand when the low multiplier bit is set,
    // then shift the whole 33-bit result right by one.
    always_comb begin
        mul_sum  = {1'b0, acc[31:16]} + (acc[0] ? {1'b0, b_mag} : 17'd0);
        mul_next = {mul_sum, acc[15:1]};
    end

    // One restoring divide step. The shifted remainder can reach 17 bits, so the
    // trial subtract is 17 bits wide and bit 16 acts as the borrow.
    always_comb begin
        rem_shift = {acc[31:16], acc[15]};
        div_diff  = rem_shift - {1'b0, b_mag};
        if (!div_diff[16]) begin
            div_next = {div_diff[15:0], acc[14:0], 1'b1};
        end else begin
            div_next = {rem_shift[15:0], acc[14:0], 1'b0};
        end
    end

    // Sign correction for the FIX cycle
    always_comb begin
        prod_fixed = (a_neg ^ b_neg) ? (~acc + 32'd1) : acc;
        quot_fixed = (a_neg ^ b_neg) ? (~acc[15:0] + 16'd1) : acc[15:0];
        rem_fixed  = a_neg ? (~acc[31:16] + 16'd1) : acc[31:16];
        fix_dbz    = 1'b0;
        if (op_reg[1]) begin
            if (b_mag == 16'd0) begin
                fix_dbz = 1'b1;
                fix_hi  = a_raw;
                fix_lo  = 16'hFFFF;
            end else begin
                fix_hi  = rem_fixed;
                fix_lo  = quot_fixed;
            end
        end else begin
            fix_hi = prod_fixed[31:16];
            fix_lo = prod_fixed[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            iter_cnt    <= 5'd0;
            op_reg      <= OP_MULTU;
            a_raw       <= 16'd0;
            b_mag       <= 16'd0;
            a_neg       <= 1'b0;
            b_neg       <= 1'b0;
            acc         <= 32'd0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi_we       <= 1'b0;
            lo_we       <= 1'b0;
            hi_data     <= 16'd0;
            lo_data     <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_reg   <= op;
                        a_raw    <= a;
                        b_mag    <= b_in_mag;
                        a_neg    <= a_in_neg;
                        b_neg    <= b_in_neg;
                        acc      <= {16'd0, a_in_mag};
                        iter_cnt <= 5'd0;
                        state    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc      <= op_reg[1] ? div_next : mul_next;
                    iter_cnt <= iter_cnt + 5'd1;
                    if (iter_cnt == ITER_LAST) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_data     <= fix_hi;
                    lo_data     <= fix_lo;
                    div_by_zero <= fix_dbz;
                    done        <= 1'b1;
                    hi_we       <= 1'b1;
                    lo_we       <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    done        <= 1'b0;
                    div_by_zero <= 1'b0;
                    hi_we       <= 1'b0;
                    lo_we       <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Directed, table-driven bench for muldiv_unit: applies hand-computed
// vectors, then exercises start-while-busy, reset mid-operation and
// back-to-back starts.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        hi_we;
    logic        lo_we;
    logic [15:0] hi_data;
    logic [15:0] lo_data;

    int checks   = 0;
    int failures = 0;

    muldiv_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .hi_data     (hi_data),
        .lo_data     (lo_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] hi;
        logic [15:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launches one operation with start high in cycle 0 and follows it to cycle 18.
    // The first sample (before driving start) is cycle 19 of the previous operation.
    // glitch_cyc != 0 pulses start with different operands during that cycle.
    task automatic run_op(input string name, input logic [1:0] v_op, input logic [15:0] v_a,
                          input logic [15:0] v_b, input logic [15:0] exp_hi,
                          input logic [15:0] exp_lo, input logic exp_dbz, input int glitch_cyc);
        int          done_cnt = 0;
        int          done_cyc = 0;
        int          bad_busy = 0;
        int          bad_we   = 0;
        int          bad_dbz  = 0;
        logic [15:0] got_hi   = 16'h0;
        logic [15:0] got_lo   = 16'h0;
        logic        got_dbz  = 1'b0;
        @(negedge clk);
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_idle_done"}, done, 0);
        start = 1'b1;
        op    = v_op;
        a     = v_a;
        b     = v_b;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                // operands need not be held after the start cycle
                start = 1'b0;
                op    = ~v_op;
                a     = 16'hDEAD;
                b     = 16'h0000;
            end
            if (glitch_cyc != 0 && cyc == glitch_cyc) begin
                start = 1'b1;
                op    = OP_DIV;
                a     = 16'h7FFF;
                b     = 16'h0003;
            end
            if (glitch_cyc != 0 && cyc == glitch_cyc + 1) start = 1'b0;
            if (busy !== 1'b1) bad_busy++;
            if (hi_we !== done || lo_we !== done) bad_we++;
            if (div_by_zero === 1'b1 && done !== 1'b1) bad_dbz++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                got_hi   = hi_data;
                got_lo   = lo_data;
                got_dbz  = div_by_zero;
            end
        end
        check({name, "_done_count"}, done_cnt, 1);
        check({name, "_done_cycle"}, done_cyc, 18);
        check({name, "_hi"}, got_hi, exp_hi);
        check({name, "_lo"}, got_lo, exp_lo);
        check({name, "_dbz"}, got_dbz, exp_dbz);
        check({name, "_busy_1to18"}, bad_busy, 0);
        check({name, "_we_with_done"}, bad_we, 0);
        check({name, "_dbz_outside_done"}, bad_dbz, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int extra_pulse;

        vecs[0]  = '{"multu_ffff", OP_MULTU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0};
        vecs[1]  = '{"mult_m3x5",  OP_MULT,  16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1, 1'b0};
        vecs[2]  = '{"divu_100_7", OP_DIVU,  16'd100,  16'd7,    16'h0002, 16'h000E, 1'b0};
        vecs[3]  = '{"div_m7_2",   OP_DIV,   16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0};
        vecs[4]  = '{"div_min_m1", OP_DIV,   16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0};
        vecs[5]  = '{"divu_dbz",   OP_DIVU,  16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1};
        vecs[6]  = '{"div_dbz",    OP_DIV,   16'hFFF9, 16'h0000, 16'hFFF9, 16'hFFFF, 1'b1};
        vecs[7]  = '{"div_7_m2",   OP_DIV,   16'h0007, 16'hFFFE, 16'h0001, 16'hFFFD, 1'b0};
        vecs[8]  = '{"div_m7_m2",  OP_DIV,   16'hFFF9, 16'hFFFE, 16'hFFFF, 16'h0003, 1'b0};
        vecs[9]  = '{"mult_min2",  OP_MULT,  16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0};
        vecs[10] = '{"multu_small", OP_MULTU, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        op    = OP_MULTU;
        a     = 16'h0;
        b     = 16'h0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_we", {hi_we, lo_we}, 0);
        check("rst_hi", hi_data, 0);
        check("rst_lo", lo_data, 0);
        reset = 1'b0;

        // each run starts in cycle 19 of the previous one: back-to-back
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dbz, 0);
        end

        // start pulse during cycle 5 must be ignored
        run_op("busy_start", OP_MULTU, 16'h0003, 16'h0004, 16'h0000, 16'h000C, 1'b0, 5);

        // reset in cycle 10 aborts with no write pulse
        @(negedge clk);
        start = 1'b1;
        op    = OP_MULTU;
        a     = 16'h0101;
        b     = 16'h0202;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_we", {hi_we, lo_we}, 0);
        check("abort_hi", hi_data, 0);
        check("abort_lo", lo_data, 0);
        @(negedge clk);
        reset = 1'b0;
        extra_pulse = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk);
            if (hi_we !== 1'b0 || lo_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0)
                extra_pulse++;
        end
        check("abort_no_pulse", extra_pulse, 0);

        run_op("after_abort", OP_DIVU, 16'd1000, 16'd3, 16'h0001, 16'h014D, 1'b0, 0);

        @(negedge clk);
        check("final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 16-bit multiply/divide unit in the execute stage, feeding the HI/LO write ports of the register file. A single-cycle `start` pulse launches a signed or unsigned multiply or divide. After a fixed latency the unit presents a one-cycle write pulse with the 32-bit product, or the quotient and remainder, split across HI and LO. One operation is in flight at a time; the core stalls on `busy`.

## Interface
- No parameters; datapath width is fixed at 16 bits.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: launch request; sampled only while idle.
- `op` input 2: operation select. 00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
- `a` input 16: multiplicand or dividend; sampled with `start`.
- `b` input 16: multiplier or divisor; sampled with `start`.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle completion pulse.
- `div_by_zero` output 1: qualifies `done` for a DIV/DIVU with `b == 0`.
- `hi_we` output 1: HI write enable; same cycle as `done`.
- `lo_we` output 1: LO write enable; same cycle as `done`.
- `hi_data` output 16: product[31:16] or remainder.
- `lo_data` output 16: product[15:0] or quotient.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE:**
  - When `start` is high, latch `op`, |a|, |b| and the operand signs, clear the 5-bit iteration counter, and go to CALC.
  - Magnitudes apply only to signed ops; unsigned ops latch raw values.
- **CALC:** one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, on a 32-bit accumulator. After the 16th step, go to FIX.
- **FIX:**
  - Sign correction. MULT negates the 32-bit product when the operand signs differ.
  - DIV negates the quotient when the signs differ, and gives the remainder the sign of the dividend (truncation toward zero).
  - Results are registered into `hi_data`/`lo_data`; go to DONE.
- **DONE:** assert `done`, `hi_we` and `lo_we` for exactly one cycle, then return to IDLE.
- **Width rules:**
  - |−32768| = 0x8000, held as unsigned 16-bit.
  - Signed −32768 / −1 gives `lo_data` = 0x8000, `hi_data` = 0x0000, with no overflow flag.
- **Divide by zero:**
  - The full latency still runs.
  - Result is `lo_data` = 0xFFFF and `hi_data` = `a` (the original signed value), for both DIV and DIVU.
  - `div_by_zero` is high in the DONE cycle only.
- **Start while busy:** `start` is ignored; the in-flight operation is unaffected and inputs are not resampled.
- **Operand hold:** `a`, `b` and `op` need not be held after the `start` cycle.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycles 1–16: CALC.
- Cycle 17: FIX.
- Cycle 18: DONE, with `done`/`hi_we`/`lo_we` high.
- `busy` = (state != IDLE), i.e. high in cycles 1–18.
- Back-to-back: the earliest next accepted `start` is in cycle 19.
- Latency is 18 cycles, independent of op and operand values.
- `hi_data`/`lo_data` are stable from cycle 18 until the next FIX. Outside DONE they are don't-care to the consumer, but are held (not cleared).
- **Reset values:**
  - State IDLE, counter 0.
  - `busy`, `done`, `div_by_zero`, `hi_we` and `lo_we` are 0.
  - `hi_data` and `lo_data` are 0x0000.
- **Reset mid-operation:** immediate abort to IDLE. No write pulse is ever emitted for the aborted operation.
- **Registered outputs:** all outputs are registered except `busy`, which is decoded from registered state.

## Structure
- The shared package holds:
  - `op` encodings: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV.
  - State encoding.
  - Constant ITER_COUNT = 16.
- There is no sub-module. Sign handling, accumulator and FSM live in one module of about 200 lines.
- The instruction decoder drives `start`/`op` and connects HI/LO outputs directly to the register file's `hi_we`/`lo_we`/`hi_data`/`lo_data`.

## Test plan
- **MULTU:** a=0xFFFF, b=0xFFFF → cycle 18: hi=0xFFFE, lo=0x0001, `hi_we`=`lo_we`=`done`=1 for one cycle.
- **MULT:** a=0xFFFD (−3), b=0x0005 → hi=0xFFFF, lo=0xFFF1.
- **DIVU:** a=100, b=7 → lo=0x000E, hi=0x0002.
- **DIV:**
  - a=0xFFF9 (−7), b=2 → lo=0xFFFD, hi=0xFFFF.
  - a=0x8000, b=0xFFFF → lo=0x8000, hi=0x0000.
- **Divide by zero:** DIVU a=0x1234, b=0 → lo=0xFFFF, hi=0x1234, `div_by_zero`=1 only in cycle 18.
- **Control:**
  - A `start` pulse in cycle 5 of an operation is ignored: exactly one `done` appears, in cycle 18.
  - Reset asserted in cycle 10 → all outputs 0 immediately, with no `hi_we`/`lo_we` pulse afterwards.
  - A fresh `start` in cycle 19 completes normally.
